// File: rtl/sr_qstack.sv
// sr_qstack: parametrised FIFO/LIFO operand buffer for the CPU push/pop path.
// Circular array of DEPTH words with occupancy count, sticky overflow and
// underflow flags, and defined simultaneous push/pop behaviour.
// Optional macro SR_QSTACK_ALMOST_EN builds registered almostFull/almostEmpty
// flags; without it both outputs are tied to 0.
// Handshake: there is no back-pressure. push/pop are single-cycle strobes
// sampled on the rising edge of clk; a refused push or pop sets ovf/udf.
module sr_qstack #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = $clog2(DEPTH + 1),
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             udf,
  input  logic             clrErr,
  output logic             almostFull,
  output logic             almostEmpty,
  output logic             o_dbg_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Mode latch FSM: IDLE while empty (mode follows input), ACTIVE otherwise.
  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_udf;
  logic             r_mode;
  state_t           r_state;

  logic             w_empty;
  logic             w_full;
  logic [PTR_W-1:0] w_top;
  logic [PTR_W-1:0] w_wr_nx;
  logic [PTR_W-1:0] w_rd_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_we;
  logic [PTR_W-1:0] w_waddr;
  logic             w_set_ovf;
  logic             w_set_udf;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(DEPTH - 1) : p - PTR_W'(1);
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_top   = ptr_dec(r_wr);

  // Next pointers, count, write strobe and error events for this cycle.
  always_comb begin
    w_wr_nx   = r_wr;
    w_rd_nx   = r_rd;
    w_cnt_nx  = r_count;
    w_we      = 1'b0;
    w_waddr   = r_wr;
    w_set_ovf = 1'b0;
    w_set_udf = 1'b0;
    if (push && pop && !w_empty) begin
      // Paired op on a non-empty buffer: occupancy never changes.
      w_we = 1'b1;
      if (r_mode) begin
        w_waddr = w_top;
      end else begin
        w_wr_nx = ptr_inc(r_wr);
        w_rd_nx = ptr_inc(r_rd);
      end
    end else begin
      if (push) begin
        if (w_full) begin
          w_set_ovf = 1'b1;
        end else begin
          w_we     = 1'b1;
          w_wr_nx  = ptr_inc(r_wr);
          w_cnt_nx = r_count + CNT_W'(1);
        end
      end
      // Only reachable with push when empty, so the pop is always refused there.
      if (pop) begin
        if (w_empty) begin
          w_set_udf = 1'b1;
        end else if (r_mode) begin
          w_wr_nx  = ptr_dec(r_wr);
          w_cnt_nx = r_count - CNT_W'(1);
        end else begin
          w_rd_nx  = ptr_inc(r_rd);
          w_cnt_nx = r_count - CNT_W'(1);
        end
      end
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && w_we) r_mem[w_waddr] <= pushData;
  end

  // Pointers, count and sticky error flags (new error beats clrErr).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_wr    <= w_wr_nx;
      r_rd    <= w_rd_nx;
      r_count <= w_cnt_nx;
      r_ovf   <= w_set_ovf | (r_ovf & ~clrErr);
      r_udf   <= w_set_udf | (r_udf & ~clrErr);
    end
  end

  // Mode latch FSM: mode tracks the input only while the buffer is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= 1'b0;
      r_state <= ST_IDLE;
    end else begin
      if (w_empty) r_mode <= mode;
      r_state <= (w_cnt_nx != '0) ? ST_ACTIVE : ST_IDLE;
    end
  end

`ifdef SR_QSTACK_ALMOST_EN
  logic r_af;
  logic r_ae;

  // Threshold flags track the post-update count on the same edge as count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_af <= 1'b0;
      r_ae <= 1'b1;
    end else begin
      r_af <= (w_cnt_nx >= CNT_W'(AF_LEVEL));
      r_ae <= (w_cnt_nx <= CNT_W'(AE_LEVEL));
    end
  end

  assign almostFull  = r_af;
  assign almostEmpty = r_ae;
`else
  assign almostFull  = 1'b0;
  assign almostEmpty = 1'b0;
`endif

  assign popData     = w_empty ? '0 : (r_mode ? r_mem[w_top] : r_mem[r_rd]);
  assign empty       = w_empty;
  assign full        = w_full;
  assign count       = r_count;
  assign ovf         = r_ovf;
  assign udf         = r_udf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sr_qstack.sv
// tb_sr_qstack: directed bench for sr_qstack (WIDTH=8, DEPTH=4) with a
// queue-based reference model compared every cycle, plus literal checks.
module tb_sr_qstack;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic          push;
  logic [W-1:0]  pushData;
  logic          pop;
  logic          clrErr;
  logic [W-1:0]  popData;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          ovf;
  logic          udf;
  logic          almostFull;
  logic          almostEmpty;
  logic          dbg_state;

  sr_qstack #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .rst(rst), .mode(mode), .push(push), .pushData(pushData),
    .pop(pop), .popData(popData), .empty(empty), .full(full), .count(count),
    .ovf(ovf), .udf(udf), .clrErr(clrErr), .almostFull(almostFull),
    .almostEmpty(almostEmpty), .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [W-1:0] exp_q[$];
  bit m_mode = 1'b0;
  bit m_ovf  = 1'b0;
  bit m_udf  = 1'b0;
  bit m_af   = 1'b0;
  bit m_ae   = 1'b0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_almost();
`ifdef SR_QSTACK_ALMOST_EN
    m_af = (exp_q.size() >= 3);
    m_ae = (exp_q.size() <= 1);
`else
    m_af = 1'b0;
    m_ae = 1'b0;
`endif
  endtask

  // driver: one clock with the given inputs, then advance the model
  task automatic step(input bit ps, input logic [W-1:0] d, input bit pp,
                      input bit md, input bit clr);
    bit was_empty;
    bit e_ovf;
    bit e_udf;
    push = ps; pushData = d; pop = pp; mode = md; clrErr = clr;
    @(posedge clk);
    was_empty = (exp_q.size() == 0);
    e_ovf = 1'b0;
    e_udf = 1'b0;
    if (ps && pp && !was_empty) begin
      if (m_mode) exp_q[exp_q.size()-1] = d;
      else begin
        void'(exp_q.pop_front());
        exp_q.push_back(d);
      end
    end else begin
      if (pp) begin
        if (was_empty) e_udf = 1'b1;
        else if (m_mode) void'(exp_q.pop_back());
        else void'(exp_q.pop_front());
      end
      if (ps) begin
        if (exp_q.size() == D) e_ovf = 1'b1;
        else exp_q.push_back(d);
      end
    end
    if (was_empty) m_mode = md;
    m_ovf = e_ovf | (m_ovf & !clr);
    m_udf = e_udf | (m_udf & !clr);
    model_almost();
    #1;
    push = 1'b0; pop = 1'b0; clrErr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; push = 1'b1; pop = 1'b1; pushData = 8'hEE; mode = 1'b1;
    @(posedge clk);
    exp_q.delete();
    m_mode = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
`ifdef SR_QSTACK_ALMOST_EN
    m_af = 1'b0; m_ae = 1'b1;
`else
    m_af = 1'b0; m_ae = 1'b0;
`endif
    #1;
    rst = 1'b0; push = 1'b0; pop = 1'b0; mode = 1'b0; clrErr = 1'b0;
  endtask

  // scoreboard compare on the falling edge, away from the sampling edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [W-1:0] e_pd;
      e_pd = (exp_q.size() == 0) ? '0 : (m_mode ? exp_q[$] : exp_q[0]);
      chk("m_popData", 32'(popData), 32'(e_pd));
      chk("m_count", 32'(count), 32'(exp_q.size()));
      chk("m_empty", 32'(empty), 32'(exp_q.size() == 0));
      chk("m_full", 32'(full), 32'(exp_q.size() == D));
      chk("m_ovf", 32'(ovf), 32'(m_ovf));
      chk("m_udf", 32'(udf), 32'(m_udf));
      chk("m_af", 32'(almostFull), 32'(m_af));
      chk("m_ae", 32'(almostEmpty), 32'(m_ae));
      chk("m_state", 32'(dbg_state), 32'(exp_q.size() != 0));
    end
  end

  logic [W-1:0] fill_v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  bit exp_af3;

  initial begin
    rst = 1'b1; mode = 1'b0; push = 1'b0; pop = 1'b0; clrErr = 1'b0; pushData = '0;
    repeat (2) @(posedge clk);
    do_reset();
    chk_en = 1'b1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_popData", 32'(popData), 32'd0);

    // FIFO fill, overflow, drain
    for (int i = 0; i < 4; i++) step(1, fill_v[i], 0, 0, 0);
    chk("fifo_full", 32'(full), 32'd1);
    chk("fifo_count4", 32'(count), 32'd4);
    step(1, 8'h55, 0, 0, 0);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("fifo_order", 32'(popData), 32'(fill_v[i]));
      step(0, 8'h00, 1, 0, 0);
    end
    chk("fifo_drained", 32'(empty), 32'd1);
    step(0, 8'h00, 0, 0, 1);
    chk("ovf_clr", 32'(ovf), 32'd0);

    // full with simultaneous push+pop
    for (int i = 0; i < 4; i++) step(1, fill_v[i], 0, 0, 0);
    chk("sim_full_pd", 32'(popData), 32'h11);
    step(1, 8'h99, 1, 0, 0);
    chk("sim_full_cnt", 32'(count), 32'd4);
    chk("sim_full_ovf", 32'(ovf), 32'd0);
    chk("sim_full_next", 32'(popData), 32'h22);
    repeat (4) step(0, 8'h00, 1, 0, 0);

    // underflow and clear
    step(0, 8'h00, 1, 0, 0);
    chk("udf_set", 32'(udf), 32'd1);
    step(0, 8'h00, 0, 0, 1);
    chk("udf_clr", 32'(udf), 32'd0);

    // LIFO
    step(1, 8'hA1, 0, 1, 0);
    step(1, 8'hA2, 0, 1, 0);
    step(1, 8'hA3, 0, 1, 0);
    chk("lifo_top", 32'(popData), 32'hA3);
    step(1, 8'hB0, 1, 1, 0);
    chk("lifo_sim_cnt", 32'(count), 32'd3);
    chk("lifo_sim_top", 32'(popData), 32'hB0);
    step(0, 8'h00, 1, 1, 0);
    chk("lifo_pop1", 32'(popData), 32'hA2);
    step(0, 8'h00, 1, 1, 0);
    chk("lifo_pop2", 32'(popData), 32'hA1);
    step(0, 8'h00, 1, 1, 0);
    chk("lifo_empty", 32'(empty), 32'd1);

    // empty with simultaneous push+pop
    step(1, 8'h07, 1, 0, 0);
    chk("sim_empty_cnt", 32'(count), 32'd1);
    chk("sim_empty_udf", 32'(udf), 32'd1);
    chk("sim_empty_pd", 32'(popData), 32'h07);
    step(0, 8'h00, 1, 0, 1);

    // FIFO wrap-around at occupancy 2
    step(1, 8'd0, 0, 0, 0);
    step(1, 8'd1, 0, 0, 0);
    for (int i = 2; i < 10; i++) begin
      chk("wrap_order", 32'(popData), 32'(i - 2));
      step(1, 8'(i), 1, 0, 0);
    end
    chk("wrap_8", 32'(popData), 32'd8);
    step(0, 8'h00, 1, 0, 0);
    chk("wrap_9", 32'(popData), 32'd9);
    step(0, 8'h00, 1, 0, 0);
    chk("wrap_empty", 32'(empty), 32'd1);

    // mode toggle while occupied is ignored
    step(1, 8'h05, 0, 0, 0);
    step(1, 8'h06, 0, 1, 0);
    chk("mode_hold0", 32'(popData), 32'h05);
    step(0, 8'h00, 1, 1, 0);
    chk("mode_hold1", 32'(popData), 32'h06);
    step(0, 8'h00, 1, 0, 0);

    // reset mid-operation with count=3 and ovf set
    for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    chk("pre_rst_cnt", 32'(count), 32'd3);
    do_reset();
    chk("mid_rst_cnt", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_udf", 32'(udf), 32'd0);

    // thresholds
`ifdef SR_QSTACK_ALMOST_EN
    exp_af3 = 1'b1;
`else
    exp_af3 = 1'b0;
`endif
    step(1, 8'hC1, 0, 0, 0);
    step(1, 8'hC2, 0, 0, 0);
    chk("af_at2", 32'(almostFull), 32'd0);
    step(1, 8'hC3, 0, 0, 0);
    chk("af_at3", 32'(almostFull), 32'(exp_af3));
    step(0, 8'h00, 1, 0, 0);
    chk("ae_at2", 32'(almostEmpty), 32'd0);
    step(0, 8'h00, 1, 0, 0);
    chk("ae_at1", 32'(almostEmpty), 32'(exp_af3));
    step(0, 8'h00, 1, 0, 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sr_qstack.md
Name: sr_qstack

Overview:
- Parametrised hardware queue/stack used as the operand buffer behind the CPU push/pop instructions. It is the successor to the fixed single-mode buffer.
- Width, depth and FIFO/LIFO mode are configurable. Adds an occupancy count, sticky overflow/underflow flags and defined simultaneous push/pop behaviour.
- Sits beside the register file. It is driven by the decode/control path, and popData feeds the writeback mux.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 8, number of entries; DEPTH >= 2; need not be a power of two.
- CNT_W, $clog2(DEPTH+1), width of count.
- AF_LEVEL, DEPTH-1, almost-full threshold (optional feature only).
- AE_LEVEL, 1, almost-empty threshold (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = FIFO, 1 = LIFO; sampled only while empty.
- push  in  1  write pushData this cycle.
- pushData  in  WIDTH  data to write.
- pop  in  1  remove the head/top entry this cycle.
- popData  out  WIDTH  current head (FIFO) or top (LIFO); first-word-fall-through.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  CNT_W  number of valid entries.
- ovf  out  1  sticky: push refused because the buffer was full.
- udf  out  1  sticky: pop refused because the buffer was empty.
- clrErr  in  1  clears ovf and udf.
- almostFull  out  1  count >= AF_LEVEL (optional feature).
- almostEmpty  out  1  count <= AE_LEVEL (optional feature).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: wrPtr = 0, rdPtr = 0, count = 0, ovf = 0, udf = 0, latched mode = 0 (FIFO). Memory contents are not reset.
- Outputs after reset: empty = 1, full = 0, popData = 0.
- Storage: circular array of DEPTH words.
  - Pointers increment/decrement modulo DEPTH: DEPTH-1 + 1 wraps to 0, and 0 - 1 wraps to DEPTH-1.
- Mode latch, two states:
  - IDLE (count == 0): the latched mode follows the mode input every clock.
  - ACTIVE (count > 0): the latched mode is frozen and mode input changes are ignored.
  - IDLE -> ACTIVE on an accepted push. ACTIVE -> IDLE when count reaches 0.
  - A push accepted in the same cycle that mode changes uses the new mode.
- popData (combinational):
  - Empty: 0.
  - FIFO: mem[rdPtr].
  - LIFO: mem[wrPtr-1 mod DEPTH].
- Latency: a pushed word is visible on popData the cycle after the push edge, when it becomes the head/top.
- Push alone:
  - Not full: mem[wrPtr] <= pushData, wrPtr++, count++.
  - Full: write discarded, state unchanged, ovf <= 1.
- Pop alone:
  - Not empty, FIFO: rdPtr++, count--.
  - Not empty, LIFO: wrPtr--, count--.
  - Empty: no change, udf <= 1.
- Push and pop in the same cycle:
  - FIFO, not empty (including full): write and read both occur; count unchanged.
  - LIFO, not empty (including full): mem[wrPtr-1] <= pushData (top replaced); pointers and count unchanged. popData shows the old top during the cycle.
  - Either mode, empty: the push is accepted, the pop is refused and udf <= 1.
  - Full with simultaneous pop never sets ovf.
- Error flags:
  - clrErr clears ovf and udf.
  - A same-cycle new error takes priority over clrErr, so the flag stays 1.
- rst mid-operation: all content is discarded (count = 0) on that edge; push/pop in the reset cycle are ignored.

Optional Feature:
- Macro: SR_QSTACK_ALMOST_EN.
- Defined: almostFull and almostEmpty are registered.
  - They update on the same edge as count, reflecting the post-update count against AF_LEVEL / AE_LEVEL.
  - Reset values: almostFull = 0, almostEmpty = 1.
- Not defined: both ports are present but tied to 0; no threshold logic is built.

Test Plan:
- WIDTH=8, DEPTH=4, FIFO: push 0x11, 0x22, 0x33, 0x44 -> full=1, count=4. Push 0x55 -> ovf=1, count=4. Four pops -> popData 0x11, 0x22, 0x33, 0x44, then empty=1.
- LIFO (mode=1 while empty): push 0xA1, 0xA2, 0xA3 -> popData=0xA3. Pop -> 0xA2; pop -> 0xA1.
- Wrap-around FIFO: run 10 push/pop pairs of values 0..9 interleaved with occupancy 2 -> output order 0..9 exact; pointers wrap with no data loss.
- Simultaneous ops:
  - FIFO full: push 0x99 + pop -> popData was 0x11, count stays 4, ovf=0.
  - LIFO with top 0xA3: push 0xB0 + pop -> count unchanged, next popData=0xB0.
  - Empty: push 0x7 + pop -> count=1, udf=1.
- Errors/mode:
  - Pop on empty -> udf=1; clrErr -> udf=0.
  - Toggle mode while count=2 -> order unchanged.
  - rst with count=3 -> count=0, empty=1, ovf=udf=0 next cycle.
- SR_QSTACK_ALMOST_EN, DEPTH=4, AF=3, AE=1: push 3 -> almostFull=1 after the 3rd edge; pop to 1 -> almostEmpty=1. Macro undefined -> both remain 0.
